// File: rtl/senone_normaliser_pkg.sv
// Shared score type, saturation limits and the 17-to-16 bit saturating narrow
// used by the senone normaliser.
package senone_normaliser_pkg;

    typedef logic signed [15:0] num;

    localparam num NUM_MIN = 16'sh8000;
    localparam num NUM_MAX = 16'sh7FFF;

    // Clamp a 17-bit signed difference into the 16-bit score range.
    function automatic num sat16(input logic signed [16:0] d);
        if (d < 17'sh1_8000) begin
            return NUM_MIN;
        end
        if (d > 17'sh0_7FFF) begin
            return NUM_MAX;
        end
        return num'(d[15:0]);
    endfunction

endpackage

// File: rtl/senone_normaliser_score_rd_pipe.sv
// Two-stage delay line that carries read address and flags alongside the
// score RAM latency. Stage 1 lines up with ram_rd_data; stage 2 lines up with
// the registered score/write outputs of the top.
// Ports: in_* (read issued this cycle), s1_valid/s1_pass2 (data present on
// the RAM read port), strobe/last_strobe (pass-1 max-unit strobes),
// wr_en/wr_last/out_addr (pass-2 write-back control).
module score_rd_pipe #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_last,
    input  logic              in_pass2,
    output logic              s1_valid,
    output logic              s1_pass2,
    output logic              strobe,
    output logic              last_strobe,
    output logic              wr_en,
    output logic              wr_last,
    output logic [ADDR_W-1:0] out_addr
);

    logic [ADDR_W-1:0] s1_addr;
    logic              s1_last;

    // Stage 1: read accepted by the RAM, data valid this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_last  <= 1'b0;
            s1_pass2 <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            s1_addr  <= in_addr;
            s1_last  <= in_valid & in_last;
            s1_pass2 <= in_pass2;
        end
    end

    // Stage 2: split into pass-1 strobes and pass-2 write controls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe      <= 1'b0;
            last_strobe <= 1'b0;
            wr_en       <= 1'b0;
            wr_last     <= 1'b0;
            out_addr    <= '0;
        end else begin
            strobe      <= s1_valid & ~s1_pass2;
            last_strobe <= s1_valid & s1_last & ~s1_pass2;
            wr_en       <= s1_valid & s1_pass2;
            wr_last     <= s1_valid & s1_last & s1_pass2;
            out_addr    <= s1_addr;
        end
    end

endmodule

// File: rtl/senone_normaliser.sv
// Frame sequencer: pass 1 streams every score to the max unit, then waits for
// its result; pass 2 rewrites each score in place as sat16(score - best).
// Ports: start/n_senones (frame request), ram_rd_*/ram_wr_* (dual-port score
// RAM), score_out/new_senone/last_senone (to max unit), best_score/max_done
// (from max unit), busy/done (status).
module senone_normaliser
    import senone_normaliser_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   n_senones,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  num                ram_rd_data,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output num                ram_wr_data,
    output num                score_out,
    output logic              new_senone,
    output logic              last_senone,
    input  num                best_score,
    input  logic              max_done,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CW = ADDR_W + 1;

    typedef enum logic [2:0] {IDLE, PASS1, WAIT, PASS2, FLUSH, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [CW-1:0]   n_q, n_nx;
    num              best_q, best_nx;
    logic            rd_en_nx;
    logic            rd_last, rd_last_nx;
    logic            rd_pass2, rd_pass2_nx;
    logic            busy_nx, done_nx;
    logic            s1_valid, s1_pass2, wr_last;
    logic signed [16:0] diff_c;

    // Counter is one bit wider than the address so a full frame never wraps.
    assign ram_rd_addr = cnt[ADDR_W-1:0];

    score_rd_pipe #(.ADDR_W(ADDR_W)) u_pipe (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (ram_rd_en),
        .in_addr     (ram_rd_addr),
        .in_last     (rd_last),
        .in_pass2    (rd_pass2),
        .s1_valid    (s1_valid),
        .s1_pass2    (s1_pass2),
        .strobe      (new_senone),
        .last_strobe (last_senone),
        .wr_en       (ram_wr_en),
        .wr_last     (wr_last),
        .out_addr    (ram_wr_addr)
    );

    // State and control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            n_q       <= '0;
            best_q    <= '0;
            ram_rd_en <= 1'b0;
            rd_last   <= 1'b0;
            rd_pass2  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            n_q       <= n_nx;
            best_q    <= best_nx;
            ram_rd_en <= rd_en_nx;
            rd_last   <= rd_last_nx;
            rd_pass2  <= rd_pass2_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

    // Next-state and next-control logic.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        n_nx        = n_q;
        best_nx     = best_q;
        rd_en_nx    = 1'b0;
        rd_last_nx  = 1'b0;
        rd_pass2_nx = rd_pass2;

        case (state)
            IDLE: begin
                if (start) begin
                    n_nx   = n_senones;
                    cnt_nx = '0;
                    if (n_senones == '0) begin
                        state_nx = DONE;
                    end else begin
                        state_nx    = PASS1;
                        rd_en_nx    = 1'b1;
                        rd_last_nx  = (n_senones == CW'(1));
                        rd_pass2_nx = 1'b0;
                    end
                end
            end
            PASS1, PASS2: begin
                // One read per cycle until the flagged last address.
                if (ram_rd_en && !rd_last) begin
                    rd_en_nx   = 1'b1;
                    cnt_nx     = cnt + CW'(1);
                    rd_last_nx = (cnt + CW'(2) == n_q);
                end
                if (state == PASS1 && last_senone) begin
                    state_nx = WAIT;
                end
                if (state == PASS2 && ram_rd_en && rd_last) begin
                    state_nx = FLUSH;
                end
            end
            WAIT: begin
                if (max_done) begin
                    best_nx     = best_score;
                    state_nx    = PASS2;
                    cnt_nx      = '0;
                    rd_en_nx    = 1'b1;
                    rd_last_nx  = (n_q == CW'(1));
                    rd_pass2_nx = 1'b1;
                end
            end
            FLUSH: begin
                if (wr_last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx == PASS1) || (state_nx == WAIT) ||
                  (state_nx == PASS2) || (state_nx == FLUSH);
        done_nx = (state_nx == DONE);
    end

    always_comb begin
        diff_c = $signed({ram_rd_data[15], ram_rd_data}) - $signed({best_q[15], best_q});
    end

    // Register RAM data onto the max-unit bus (pass 1) or the write port (pass 2).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_out   <= '0;
            ram_wr_data <= '0;
        end else if (s1_valid) begin
            if (s1_pass2) begin
                ram_wr_data <= sat16(diff_c);
            end else begin
                score_out <= ram_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_senone_normaliser.sv
// Scoreboard bench: each frame pushes expected reads, strobes, writes and the
// done cycle into queues; a negedge monitor pops and compares.
module tb_senone_normaliser;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 16;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     start;
    logic [ADDR_W:0]          n_senones;
    logic                     ram_rd_en;
    logic [ADDR_W-1:0]        ram_rd_addr;
    logic signed [15:0]       ram_rd_data;
    logic                     ram_wr_en;
    logic [ADDR_W-1:0]        ram_wr_addr;
    logic signed [15:0]       ram_wr_data;
    logic signed [15:0]       score_out;
    logic                     new_senone;
    logic                     last_senone;
    logic signed [15:0]       best_score;
    logic                     max_done;
    logic                     busy;
    logic                     done;

    senone_normaliser #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .n_senones   (n_senones),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .score_out   (score_out),
        .new_senone  (new_senone),
        .last_senone (last_senone),
        .best_score  (best_score),
        .max_done    (max_done),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int addr;
        int data;
        bit last;
    } ev_t;

    ev_t rdq[$];
    ev_t stq[$];
    ev_t wrq[$];
    int  doneq[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int busy_lo = 1;
    int busy_hi = 0;

    logic signed [15:0] mem     [DEPTH];
    logic signed [15:0] ld_data [DEPTH];
    logic               ld = 1'b0;

    logic               max_clr = 1'b0;
    int                 mdelay = 0;
    int                 pend;
    logic               have;

    int t1[4] = '{-5, 12, -300, 7};
    int e1[4] = '{-17, 0, -312, -5};

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int satf(input int v);
        if (v < -32768) return -32768;
        if (v > 32767) return 32767;
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Dual-port score RAM with a bulk-load port for the bench.
    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= ld_data[i];
        end else if (ram_wr_en) begin
            mem[ram_wr_addr] <= ram_wr_data;
        end
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    // Max-finder model with an optional extra delay before max_done.
    always @(posedge clk or posedge reset) begin
        if (reset || max_clr) begin
            best_score <= '0;
            max_done   <= 1'b0;
            pend       <= 0;
            have       <= 1'b0;
        end else begin
            if (new_senone) begin
                if (!have || score_out > best_score) best_score <= score_out;
                have <= 1'b1;
            end
            if (last_senone) begin
                if (mdelay == 0) max_done <= 1'b1;
                else pend <= mdelay;
            end
            if (pend != 0) begin
                pend <= pend - 1;
                if (pend == 1) max_done <= 1'b1;
            end
        end
    end

    // Monitor: pop and compare whenever the DUT presents something.
    always @(negedge clk) begin : mon
        ev_t e;
        if (!reset) begin
            if (ram_rd_en) begin
                chk("rd_expected", longint'(rdq.size() > 0), 1);
                if (rdq.size() > 0) begin
                    e = rdq.pop_front();
                    chk("rd_cycle", cyc, e.cyc);
                    chk("rd_addr", int'(ram_rd_addr), e.addr);
                end
            end
            if (last_senone) chk("last_with_strobe", int'(new_senone), 1);
            if (new_senone) begin
                chk("strobe_expected", longint'(stq.size() > 0), 1);
                if (stq.size() > 0) begin
                    e = stq.pop_front();
                    chk("strobe_cycle", cyc, e.cyc);
                    chk("strobe_score", int'(score_out), e.data);
                    chk("strobe_last", int'(last_senone), int'(e.last));
                end
            end
            if (ram_wr_en) begin
                chk("wr_expected", longint'(wrq.size() > 0), 1);
                if (wrq.size() > 0) begin
                    e = wrq.pop_front();
                    chk("wr_cycle", cyc, e.cyc);
                    chk("wr_addr", int'(ram_wr_addr), e.addr);
                    chk("wr_data", int'(ram_wr_data), e.data);
                end
            end
            if (done) begin
                chk("done_expected", longint'(doneq.size() > 0), 1);
                if (doneq.size() > 0) chk("done_cycle", cyc, doneq.pop_front());
                done_cnt <= done_cnt + 1;
            end
            chk("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
        end
    end

    // Reference: max over the frame, then saturated difference per entry.
    task automatic push_exp(input int n, input int d, input int s);
        int best;
        if (n == 0) begin
            doneq.push_back(s + 1);
            busy_lo = 1;
            busy_hi = 0;
            return;
        end
        best = -100000;
        for (int i = 0; i < n; i++) if (int'(mem[i]) > best) best = int'(mem[i]);
        for (int i = 0; i < n; i++) begin
            rdq.push_back('{s + 1 + i, i, 0, 1'b0});
            stq.push_back('{s + 3 + i, i, int'(mem[i]), (i == n - 1)});
        end
        for (int i = 0; i < n; i++) begin
            rdq.push_back('{s + n + 4 + d + i, i, 0, 1'b0});
            wrq.push_back('{s + n + 6 + d + i, i, satf(int'(mem[i]) - best), 1'b0});
        end
        doneq.push_back(s + 2 * n + 6 + d);
        busy_lo = s + 1;
        busy_hi = s + 2 * n + 5 + d;
    endtask

    task automatic do_load();
        ld = 1'b1;
        @(posedge clk); #1;
        ld = 1'b0;
    endtask

    task automatic load_random();
        for (int i = 0; i < DEPTH; i++) begin
            if ($urandom_range(0, 5) == 0) ld_data[i] = ($urandom_range(0, 1) != 0) ? 16'sh7FFF : 16'sh8000;
            else ld_data[i] = 16'($urandom());
        end
        do_load();
    endtask

    // Called at posedge+1 of a cycle where the DUT is idle.
    task automatic run_frame(input int n, input int d, input bit spur);
        int s, dc, base;
        s = cyc;
        dc = (n == 0) ? s + 1 : s + 2 * n + 6 + d;
        base = done_cnt;
        mdelay = d;
        push_exp(n, d, s);
        start = 1'b1;
        n_senones = 5'(n);
        max_clr = 1'b1;
        for (int k = 0; k < 4 * n + d + 40; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            max_clr = 1'b0;
            if (done_cnt != base) break;
            if (spur && (cyc == s + 2 || cyc == dc)) begin
                start = 1'b1;
                n_senones = 5'd3;
            end
        end
        chk("frame_done_count", done_cnt - base, 1);
    endtask

    task automatic check_outputs_zero(input string name);
        chk(name, longint'({ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data,
                            score_out, new_senone, last_senone, busy, done}), 0);
    endtask

    // Reset lands in the middle of pass 2 of an 8-entry frame.
    task automatic abort_frame();
        int s, best;
        int orig[DEPTH];
        for (int i = 0; i < DEPTH; i++) orig[i] = int'(mem[i]);
        best = -100000;
        for (int i = 0; i < 8; i++) if (orig[i] > best) best = orig[i];
        s = cyc;
        mdelay = 0;
        push_exp(8, 0, s);
        start = 1'b1;
        n_senones = 5'd8;
        max_clr = 1'b1;
        while (cyc < s + 15) begin
            @(posedge clk); #1;
            start = 1'b0;
            max_clr = 1'b0;
        end
        busy_lo = 1;
        busy_hi = 0;
        reset = 1'b1;
        #1;
        check_outputs_zero("abort_outputs_zero");
        rdq.delete();
        stq.delete();
        wrq.delete();
        doneq.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort_mem0", int'(mem[0]), satf(orig[0] - best));
        for (int i = 1; i < 8; i++) chk("abort_mem_untouched", int'(mem[i]), orig[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        n_senones = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_outputs_zero");
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed frame with known result.
        for (int i = 0; i < DEPTH; i++) ld_data[i] = (i < 4) ? 16'(t1[i]) : 16'sh0;
        do_load();
        run_frame(4, 0, 1'b0);
        for (int i = 0; i < 4; i++) chk("directed_mem", int'(mem[i]), e1[i]);

        // Saturation at the negative limit.
        ld_data[0] = 16'sh7FFF;
        ld_data[1] = 16'sh8000;
        do_load();
        run_frame(2, 0, 1'b0);
        chk("sat_mem0", int'(mem[0]), 0);
        chk("sat_mem1", int'(mem[1]), -32768);

        // Empty frame.
        run_frame(0, 0, 1'b0);

        // Slow max unit.
        load_random();
        run_frame(6, 5, 1'b0);

        // Ignored starts in pass 1 and on done, then back-to-back frame.
        load_random();
        run_frame(5, 0, 1'b1);
        run_frame(5, 0, 1'b0);

        // Single senone and full frame.
        load_random();
        run_frame(1, 0, 1'b0);
        load_random();
        run_frame(DEPTH, 2, 1'b0);

        // Random frames.
        for (int f = 0; f < 6; f++) begin
            load_random();
            run_frame(int'($urandom_range(1, DEPTH)), int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset mid pass 2, then a clean frame.
        load_random();
        abort_frame();
        run_frame(8, 0, 1'b0);

        chk("rdq_empty", rdq.size(), 0);
        chk("stq_empty", stq.size(), 0);
        chk("wrq_empty", wrq.size(), 0);
        chk("doneq_empty", doneq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
